rx_word_packer: RTL and testbench

RX_WORD_PACKER -- requirements
Module: rx_word_packer

---
 rtl/uart_fsm_pkg.sv | 17 +
 rtl/rx_word_packer.sv | 126 ++++++++++++
 tb/tb_rx_word_packer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fsm_pkg.sv
// Shared definitions for the UART RX/TX word FSMs: state encodings and byte width.
package uart_fsm_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        WRITE     = 2'd1,
        WAIT_FULL = 2'd2
    } fsm_state_t;

    // Saturating 8-bit increment used by the optional drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Packs received UART bytes little-endian into FIFO words with a one-word hold stage.
// Optional macro RX_OVF_COUNT_EN adds an 8-bit saturating dropped-word counter (o_ovf_count).
module rx_word_packer
    import uart_fsm_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4
)
(
    input  logic                             i_clk,
    input  logic                             i_rstn,
    input  logic                             i_rx_valid,
    input  logic [7:0]                       i_rx_byte,
    input  logic                             i_fifo_full,
    input  logic                             i_ovf_clr,
    output logic                             o_wr_en,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] o_wr_data,
    output logic                             o_busy,
    output logic                             o_overflow
`ifdef RX_OVF_COUNT_EN
    ,
    output logic [7:0]                       o_ovf_count
`endif
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W  = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    fsm_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [WORD_W-1:0] asm_reg, asm_next;
    logic [WORD_W-1:0] hold_reg, hold_next;
    logic              wr_en_reg;
    logic              ovf_reg, ovf_next;
    logic              last_byte;
    logic              drop;

    assign last_byte = i_rx_valid && (idx_reg == LAST_IDX);

    // Each byte lane loads only when the index points at it.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign asm_next[gi*BYTE_W +: BYTE_W] =
                (i_rx_valid && (idx_reg == IDX_W'(gi))) ? i_rx_byte
                                                         : asm_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        idx_next   = idx_reg;
        drop       = 1'b0;

        if (i_rx_valid) begin
            idx_next = last_byte ? '0 : idx_reg + IDX_W'(1);
        end

        case (state_reg)
            COLLECT: begin
                if (last_byte) begin
                    hold_next  = asm_next;
                    state_next = i_fifo_full ? WAIT_FULL : WRITE;
                end
            end
            WRITE: begin
                state_next = COLLECT;
            end
            WAIT_FULL: begin
                // The pending word keeps its slot; a newly completed word is lost.
                if (last_byte) begin
                    drop = 1'b1;
                end
                if (!i_fifo_full) begin
                    state_next = WRITE;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_next = drop ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf_reg);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg <= COLLECT;
            idx_reg   <= '0;
            asm_reg   <= '0;
            hold_reg  <= '0;
            wr_en_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            asm_reg   <= asm_next;
            hold_reg  <= hold_next;
            wr_en_reg <= (state_next == WRITE);
            ovf_reg   <= ovf_next;
        end
    end

`ifdef RX_OVF_COUNT_EN
    logic [7:0] ovf_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            ovf_cnt_reg <= 8'd0;
        end else if (i_ovf_clr) begin
            ovf_cnt_reg <= 8'd0;
        end else if (drop) begin
            ovf_cnt_reg <= sat_inc8(ovf_cnt_reg);
        end
    end

    assign o_ovf_count = ovf_cnt_reg;
`endif

    assign o_wr_en    = wr_en_reg;
    assign o_wr_data  = hold_reg;
    assign o_overflow = ovf_reg;
    assign o_busy     = (idx_reg != '0) || (state_reg != COLLECT);

endmodule

// File: tb/tb_rx_word_packer.sv
// Self-checking bench for rx_word_packer: vector table plus hand-written corner sequences,
// with every FIFO write checked against a scoreboard of expected words.
module tb_rx_word_packer;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_rx_valid;
    logic [7:0]  i_rx_byte;
    logic        i_fifo_full;
    logic        i_ovf_clr;
    logic        o_wr_en;
    logic [31:0] o_wr_data;
    logic        o_busy;
    logic        o_overflow;
`ifdef RX_OVF_COUNT_EN
    logic [7:0]  o_ovf_count;
`endif

    int          tests = 0;
    int          fails = 0;
    int          wr_count = 0;
    logic        last_wr = 1'b0;
    logic [31:0] sb[$];

    typedef struct {
        logic [7:0]  b [4];
        int          full_cycles;
        int          gap;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    rx_word_packer #(.BYTES_PER_WORD(4)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_rx_valid  (i_rx_valid),
        .i_rx_byte   (i_rx_byte),
        .i_fifo_full (i_fifo_full),
        .i_ovf_clr   (i_ovf_clr),
        .o_wr_en     (o_wr_en),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow)
`ifdef RX_OVF_COUNT_EN
        ,
        .o_ovf_count (o_ovf_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input int fc, input int gap, input logic [31:0] exp);
        vec_t v;
        v.b[0] = b0;
        v.b[1] = b1;
        v.b[2] = b2;
        v.b[3] = b3;
        v.full_cycles = fc;
        v.gap = gap;
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and score any write.
    task automatic tick();
        logic [31:0] exp;
        @(posedge i_clk);
        #1;
        last_wr = o_wr_en;
        if (o_wr_en) begin
            wr_count++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got %h, required no write", o_wr_data);
            end else begin
                exp = sb.pop_front();
                if (o_wr_data !== exp) begin
                    fails++;
                    $display("FAIL write_data: got %h, required %h", o_wr_data, exp);
                end else begin
                    $display("[TB] write %h", o_wr_data);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_byte  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    initial begin
        int wc;
        logic [31:0] word;

        vecs[0] = mk(8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 32'h44332211);
        vecs[1] = mk(8'hDD, 8'hCC, 8'hBB, 8'hAA, 10, 0, 32'hAABBCCDD);
        vecs[2] = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 32'h00000000);
        vecs[3] = mk(8'hFF, 8'h01, 8'h80, 8'h7E, 3, 0, 32'h7E8001FF);
        vecs[4] = mk(8'hA5, 8'h5A, 8'hC3, 8'h3C, 0, 2, 32'h3CC35AA5);

        i_rstn      = 1'b0;
        i_rx_valid  = 1'b0;
        i_rx_byte   = 8'h00;
        i_fifo_full = 1'b0;
        i_ovf_clr   = 1'b0;
        tick();
        tick();
        check("reset_wr_en", o_wr_en, 1'b0);
        check("reset_wr_data", o_wr_data, 32'h0);
        check("reset_overflow", o_overflow, 1'b0);
        check("reset_busy", o_busy, 1'b0);
`ifdef RX_OVF_COUNT_EN
        check("reset_ovf_count", o_ovf_count, 8'd0);
`endif
        i_rstn = 1'b1;
        tick();

        // Table-driven single words, some with the FIFO held full across completion.
        for (int v = 0; v < 5; v++) begin
            sb.push_back(vecs[v].exp);
            for (int k = 0; k < 4; k++) begin
                if (k == 3 && vecs[v].full_cycles > 0) i_fifo_full = 1'b1;
                send_byte(vecs[v].b[k]);
                if (k == 0) check($sformatf("v%0d_busy_partial", v), o_busy, 1'b1);
                if (k < 3) for (int g = 0; g < vecs[v].gap; g++) tick();
            end
            if (vecs[v].full_cycles == 0) begin
                check($sformatf("v%0d_latency", v), last_wr, 1'b1);
            end else begin
                wc = wr_count;
                for (int g = 0; g < vecs[v].full_cycles; g++) tick();
                check($sformatf("v%0d_held_writes", v), wr_count - wc, 0);
                check($sformatf("v%0d_busy_held", v), o_busy, 1'b1);
                i_fifo_full = 1'b0;
                tick();
                check($sformatf("v%0d_release_latency", v), last_wr, 1'b1);
            end
            check($sformatf("v%0d_overflow", v), o_overflow, 1'b0);
            tick();
            tick();
            check($sformatf("v%0d_idle_busy", v), o_busy, 1'b0);
            check($sformatf("v%0d_sb_empty", v), sb.size(), 0);
        end

        // Eight bytes while full: first word pending, second dropped.
        i_fifo_full = 1'b1;
        sb.push_back(32'h04030201);
        wc = wr_count;
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("ovf_flag", o_overflow, 1'b1);
        check("ovf_pending_data", o_wr_data, 32'h04030201);
        check("ovf_no_write", wr_count - wc, 0);
`ifdef RX_OVF_COUNT_EN
        check("ovf_count_one", o_ovf_count, 8'd1);
`endif
        i_fifo_full = 1'b0;
        tick();
        check("ovf_release_write", last_wr, 1'b1);
        tick();
        tick();
        check("ovf_single_write", wr_count - wc, 1);
        check("ovf_sticky", o_overflow, 1'b1);

        // Clear pulse.
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        check("clr_overflow", o_overflow, 1'b0);
`ifdef RX_OVF_COUNT_EN
        check("clr_ovf_count", o_ovf_count, 8'd0);
`endif

        // Clear coincident with a drop: flag set, counter cleared.
        i_fifo_full = 1'b1;
        sb.push_back(32'h14131211);
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        for (int i = 0; i < 3; i++) send_byte(8'h21 + 8'(i));
        i_ovf_clr = 1'b1;
        send_byte(8'h24);
        i_ovf_clr = 1'b0;
        check("clr_and_drop_overflow", o_overflow, 1'b1);
`ifdef RX_OVF_COUNT_EN
        check("clr_and_drop_count", o_ovf_count, 8'd0);
`endif
        i_fifo_full = 1'b0;
        tick();
        check("clr_drop_release_write", last_wr, 1'b1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        check("clr_again_overflow", o_overflow, 1'b0);

        // Reset after two bytes, with a byte presented during the reset cycle.
        send_byte(8'hE1);
        send_byte(8'hE2);
        i_rstn     = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_byte  = 8'h99;
        tick();
        i_rx_valid = 1'b0;
        i_rstn     = 1'b1;
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_wr_data", o_wr_data, 32'h0);
        wc = wr_count;
        sb.push_back(32'h04030201);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        check("midrst_latency", last_wr, 1'b1);
        tick();
        check("midrst_one_write", wr_count - wc, 1);

        // Reset while a word waits on a full FIFO: pending word discarded.
        i_fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'hF1 + 8'(i));
        check("waitrst_busy_before", o_busy, 1'b1);
        wc = wr_count;
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
        i_fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("waitrst_no_write", wr_count - wc, 0);
        check("waitrst_busy", o_busy, 1'b0);

        // Back-to-back bytes every cycle.
        wc = wr_count;
        word = 32'h0;
        for (int i = 0; i < 16; i++) begin
            word[8*(i%4) +: 8] = 8'h40 + 8'(i);
            if (i % 4 == 3) sb.push_back(word);
            i_rx_byte  = 8'h40 + 8'(i);
            i_rx_valid = 1'b1;
            tick();
        end
        i_rx_valid = 1'b0;
        tick();
        tick();
        check("b2b_writes", wr_count - wc, 4);
        check("b2b_overflow", o_overflow, 1'b0);
        check("b2b_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
